v_tbl_sched: RTL and testbench
==============================

V_TBL_SCHED -- requirements
Module: v_tbl_sched

Interface
REQ-001 SHALL have parameter W, default 64, state-table entry width in bits.
REQ-002 SHALL have parameter N, default 128, state-table depth in contexts; AW = $clog2(N).
REQ-003 SHALL have parameter INIT_VALUE, default '0, W-bit value written to every entry during initialisation.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port i_reinit  input  1  single-cycle request to re-run table initialisation.
REQ-007 SHALL have port i_upd_vld  input  1  update-pipe write request valid.
REQ-008 SHALL have port i_upd_addr  input  AW  update-pipe write context address.
REQ-009 SHALL have port i_upd_data  input  W  update-pipe write data.
REQ-010 SHALL have port o_upd_rdy  output  1  update-pipe write accepted this cycle (combinational).
REQ-011 SHALL have port i_clr_vld  input  1  context-clear request valid.
REQ-012 SHALL have port i_clr_addr  input  AW  context to clear to INIT_VALUE.
REQ-013 SHALL have port o_clr_rdy  output  1  clear request accepted this cycle (combinational).
REQ-014 SHALL have port o_wen_r  output  1  registered SRAM write enable.
REQ-015 SHALL have port o_waddr_r  output  AW  registered SRAM write address.
REQ-016 SHALL have port o_wdata_r  output  W  registered SRAM write data.
REQ-017 SHALL have port o_busy_r  output  1  initialisation sweep in progress.

Function
REQ-018 SHALL implement FSM states INIT and RUN; INIT is entered on reset and on i_reinit.
REQ-019 In INIT, SHALL issue one write per cycle, addresses 0..N-1 ascending, data INIT_VALUE; o_wen_r=1 with o_waddr_r=k in cycle k+1 after entry.
REQ-020 SHALL hold o_busy_r=1 for the whole of INIT, clearing it in the cycle after the address N-1 write is presented, coincident with entry to RUN.
REQ-021 In INIT, o_upd_rdy and o_clr_rdy SHALL be 0; requesters hold their valids and payloads stable until accepted.
REQ-022 In RUN, a request SHALL be accepted when vld and rdy are both 1; the write appears on o_wen_r/o_waddr_r/o_wdata_r exactly one cycle later. Clear writes carry INIT_VALUE.
REQ-023 In RUN with a single valid requester, SHALL grant it in the same cycle; throughput is one write per cycle.
REQ-024 In RUN with both valid, SHALL grant round-robin: the requester not granted most recently wins. The pointer resets to favour update.
REQ-025 SHALL never assert both rdy outputs in the same cycle.
REQ-026 With no acceptance in a cycle, o_wen_r SHALL be 0 the next cycle; o_waddr_r and o_wdata_r hold their last values.
REQ-027 i_reinit in RUN SHALL suppress both rdy outputs that cycle and enter INIT at address 0 the next cycle. A write already accepted in the previous cycle still completes.
REQ-028 i_reinit during INIT SHALL restart the sweep at address 0 the next cycle; o_busy_r remains 1.
REQ-029 The address counter SHALL stop at N-1 and SHALL NOT wrap. N that is not a power of two SHALL be supported.

Reset
REQ-030 On rst low, SHALL asynchronously set state=INIT, address counter=0, RR pointer=update, o_wen_r=0, o_waddr_r=0, o_wdata_r=0 and o_busy_r=1; both rdy outputs read 0.
REQ-031 The first INIT write (address 0) SHALL appear in the first cycle after the first rising clk edge with rst high.
REQ-032 Reset asserted mid-sweep or mid-RUN SHALL abandon all in-progress activity; the sweep restarts from 0 after release.

Configuration
REQ-033 With V_TBL_SCHED_STATS_EN defined, SHALL add output o_stall_cnt_r (16 bits, reset 0). It increments by 1, saturating at 16'hFFFF, in every RUN cycle in which a valid requester is not granted. It clears on i_reinit.
REQ-034 Without V_TBL_SCHED_STATS_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification (N=4, W=8, INIT_VALUE=8'hA5)
REQ-035 Release reset, no requests -> o_wen_r=1 with addresses 0,1,2,3 and data A5 on cycles 1-4; o_busy_r falls in cycle 5; o_wen_r=0 afterwards.
REQ-036 Requests held during INIT: upd (addr 2, data 3C) and clr (addr 1) -> no rdy before cycle 5; upd is granted in cycle 5 (write 2/3C in cycle 6); clr is granted in cycle 6 (write 1/A5 in cycle 7).
REQ-037 Both valid for 4 consecutive RUN cycles -> grants alternate upd, clr, upd, clr; rdy outputs are never both 1; with STATS_EN, o_stall_cnt_r = 4.
REQ-038 i_reinit pulsed in the same cycle as upd_vld in RUN -> o_upd_rdy=0; address 0..3 writes follow; the upd write lands after o_busy_r falls.
REQ-039 rst pulsed low while the sweep is at address 2 -> outputs return to reset values immediately; after release the sweep restarts at 0.
REQ-040 Single upd stream (addresses 0,1,2,3 back-to-back) -> four consecutive o_wen_r=1 cycles, each one cycle after acceptance, in order.

Source files
------------

// File: rtl/v_tbl_sched.sv
// State-table write scheduler: sweeps the table to INIT_VALUE, then arbitrates update and clear writes.
// Optional feature: define V_TBL_SCHED_STATS_EN to add the o_stall_cnt_r stall counter.
module v_tbl_sched #(
    parameter int            W          = 64,
    parameter int            N          = 128,
    parameter logic [W-1:0]  INIT_VALUE = '0,
    localparam int           AW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_reinit,
    input  logic          i_upd_vld,
    input  logic [AW-1:0] i_upd_addr,
    input  logic [W-1:0]  i_upd_data,
    output logic          o_upd_rdy,
    input  logic          i_clr_vld,
    input  logic [AW-1:0] i_clr_addr,
    output logic          o_clr_rdy,
    output logic          o_wen_r,
    output logic [AW-1:0] o_waddr_r,
    output logic [W-1:0]  o_wdata_r,
    output logic          o_busy_r
`ifdef V_TBL_SCHED_STATS_EN
    ,
    output logic [15:0]   o_stall_cnt_r
`endif
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    state_t        state_reg, state_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          done_reg, done_next;
    logic          prefer_clr_reg, prefer_clr_next;
    logic          wen_next;
    logic [AW-1:0] waddr_next;
    logic [W-1:0]  wdata_next;
    logic          busy_next;
    logic          upd_rdy, clr_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_INIT;
            cnt_reg        <= '0;
            done_reg       <= 1'b0;
            prefer_clr_reg <= 1'b0;
            o_wen_r        <= 1'b0;
            o_waddr_r      <= '0;
            o_wdata_r      <= '0;
            o_busy_r       <= 1'b1;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            done_reg       <= done_next;
            prefer_clr_reg <= prefer_clr_next;
            o_wen_r        <= wen_next;
            o_waddr_r      <= waddr_next;
            o_wdata_r      <= wdata_next;
            o_busy_r       <= busy_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        done_next       = done_reg;
        prefer_clr_next = prefer_clr_reg;
        wen_next        = 1'b0;
        waddr_next      = o_waddr_r;
        wdata_next      = o_wdata_r;
        busy_next       = o_busy_r;
        upd_rdy         = 1'b0;
        clr_rdy         = 1'b0;

        if (state_reg == ST_INIT) begin
            busy_next = 1'b1;
            if (i_reinit) begin
                cnt_next  = '0;
                done_next = 1'b0;
            end else if (!done_reg) begin
                wen_next   = 1'b1;
                waddr_next = cnt_reg;
                wdata_next = INIT_VALUE;
                // Counter parks on the last address; done_reg marks that it was written.
                if (cnt_reg == LAST_ADDR) begin
                    done_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end else begin
                state_next = ST_RUN;
                busy_next  = 1'b0;
                done_next  = 1'b0;
            end
        end else begin
            if (i_reinit) begin
                state_next = ST_INIT;
                busy_next  = 1'b1;
                cnt_next   = '0;
                done_next  = 1'b0;
            end else begin
                // Update wins unless both are valid and update was granted last.
                upd_rdy = i_upd_vld && (!i_clr_vld || !prefer_clr_reg);
                clr_rdy = i_clr_vld && !upd_rdy;
                if (upd_rdy) begin
                    wen_next        = 1'b1;
                    waddr_next      = i_upd_addr;
                    wdata_next      = i_upd_data;
                    prefer_clr_next = 1'b1;
                end else if (clr_rdy) begin
                    wen_next        = 1'b1;
                    waddr_next      = i_clr_addr;
                    wdata_next      = INIT_VALUE;
                    prefer_clr_next = 1'b0;
                end
            end
        end
    end

    assign o_upd_rdy = upd_rdy;
    assign o_clr_rdy = clr_rdy;

`ifdef V_TBL_SCHED_STATS_EN
    logic stall;

    assign stall = (state_reg == ST_RUN) && !i_reinit &&
                   ((i_upd_vld && !upd_rdy) || (i_clr_vld && !clr_rdy));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_stall_cnt_r <= '0;
        end else if (i_reinit) begin
            o_stall_cnt_r <= '0;
        end else if (stall && (o_stall_cnt_r != 16'hFFFF)) begin
            o_stall_cnt_r <= o_stall_cnt_r + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_v_tbl_sched.sv
// Randomized scoreboard bench for v_tbl_sched (N=4, W=8, INIT_VALUE=A5).
module tb_v_tbl_sched;

    localparam int          W  = 8;
    localparam int          N  = 4;
    localparam int          AW = 2;
    localparam logic [W-1:0] IV = 8'hA5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_reinit = 1'b0;
    logic          i_upd_vld = 1'b0;
    logic [AW-1:0] i_upd_addr = '0;
    logic [W-1:0]  i_upd_data = '0;
    logic          o_upd_rdy;
    logic          i_clr_vld = 1'b0;
    logic [AW-1:0] i_clr_addr = '0;
    logic          o_clr_rdy;
    logic          o_wen_r;
    logic [AW-1:0] o_waddr_r;
    logic [W-1:0]  o_wdata_r;
    logic          o_busy_r;
`ifdef V_TBL_SCHED_STATS_EN
    logic [15:0]   o_stall_cnt_r;
`endif

    v_tbl_sched #(.W(W), .N(N), .INIT_VALUE(IV)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_reinit   (i_reinit),
        .i_upd_vld  (i_upd_vld),
        .i_upd_addr (i_upd_addr),
        .i_upd_data (i_upd_data),
        .o_upd_rdy  (o_upd_rdy),
        .i_clr_vld  (i_clr_vld),
        .i_clr_addr (i_clr_addr),
        .o_clr_rdy  (o_clr_rdy),
        .o_wen_r    (o_wen_r),
        .o_waddr_r  (o_waddr_r),
        .o_wdata_r  (o_wdata_r),
        .o_busy_r   (o_busy_r)
`ifdef V_TBL_SCHED_STATS_EN
        ,
        .o_stall_cnt_r (o_stall_cnt_r)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [W-1:0]  d;
        int            cyc;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Reference model: sweep position, init flag, round-robin preference, stall count.
    bit  m_init = 1'b1;
    int  m_ptr = 0;
    bit  m_prefer_clr = 1'b0;
    int  m_stall = 0;

    // Requesters: hold a request until it is granted.
    bit            u_pend = 1'b0;
    bit            c_pend = 1'b0;
    logic [AW-1:0] u_a = '0;
    logic [AW-1:0] c_a = '0;
    logic [W-1:0]  u_d = '0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endfunction

    function automatic void push_wr(input logic [AW-1:0] a, input logic [W-1:0] d, input int c);
        wr_t w;
        w.a = a;
        w.d = d;
        w.cyc = c;
        exp_q.push_back(w);
    endfunction

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_wen", o_wen_r, 0);
        chk("rst_waddr", o_waddr_r, 0);
        chk("rst_wdata", o_wdata_r, 0);
        chk("rst_busy", o_busy_r, 1);
        chk("rst_upd_rdy", o_upd_rdy, 0);
        chk("rst_clr_rdy", o_clr_rdy, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        cyc = 0;
        m_init = 1'b1;
        m_ptr = 0;
        m_prefer_clr = 1'b0;
        m_stall = 0;
    endtask

    task automatic tick(input bit reinit);
        bit eu, ec, eb;
        i_reinit   = reinit;
        i_upd_vld  = u_pend;
        i_upd_addr = u_a;
        i_upd_data = u_d;
        i_clr_vld  = c_pend;
        i_clr_addr = c_a;
        @(negedge clk);
        eu = 1'b0;
        ec = 1'b0;
`ifdef V_TBL_SCHED_STATS_EN
        chk("stall_cnt", o_stall_cnt_r, m_stall);
`endif
        if (m_init) begin
            eb = 1'b1;
            if (reinit) begin
                m_ptr = 0;
            end else if (m_ptr < N) begin
                push_wr(AW'(m_ptr), IV, cyc + 1);
                m_ptr++;
            end else begin
                m_init = 1'b0;
            end
        end else begin
            eb = 1'b0;
            if (reinit) begin
                m_init = 1'b1;
                m_ptr = 0;
            end else begin
                if (u_pend && c_pend) begin
                    if (m_prefer_clr) ec = 1'b1;
                    else eu = 1'b1;
                    if (m_stall < 65535) m_stall++;
                end else begin
                    eu = u_pend;
                    ec = c_pend;
                end
                if (eu) begin
                    push_wr(u_a, u_d, cyc + 1);
                    m_prefer_clr = 1'b1;
                end
                if (ec) begin
                    push_wr(c_a, IV, cyc + 1);
                    m_prefer_clr = 1'b0;
                end
            end
        end
        if (reinit) m_stall = 0;
        chk("upd_rdy", o_upd_rdy, eu);
        chk("clr_rdy", o_clr_rdy, ec);
        chk("busy", o_busy_r, eb);
        @(posedge clk);
        cyc++;
        #1;
        if (eu) u_pend = 1'b0;
        if (ec) c_pend = 1'b0;
    endtask

    task automatic new_upd();
        u_pend = 1'b1;
        u_a = AW'($urandom_range(0, N - 1));
        u_d = W'($urandom);
    endtask

    task automatic new_clr();
        c_pend = 1'b1;
        c_a = AW'($urandom_range(0, N - 1));
    endtask

    // Monitor: every presented write must match the oldest expected write, on its cycle.
    initial begin
        wr_t           e;
        logic [AW-1:0] last_a = '0;
        logic [W-1:0]  last_d = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                exp_q.delete();
                last_a = '0;
                last_d = '0;
            end else if (o_wen_r) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr_unexpected cyc=%0d: got write addr %0h data %0h, expected no write",
                             cyc, o_waddr_r, o_wdata_r);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_cycle", cyc, e.cyc);
                    chk("wr_addr", o_waddr_r, e.a);
                    chk("wr_data", o_wdata_r, e.d);
                end
                last_a = o_waddr_r;
                last_d = o_wdata_r;
            end else begin
                chk("hold_addr", o_waddr_r, last_a);
                chk("hold_data", o_wdata_r, last_d);
            end
        end
    end

    initial begin
        #2;
        // Plain sweep after reset, then idle.
        do_reset();
        repeat (8) tick(1'b0);

        // Requests held from before reset release.
        u_pend = 1'b1; u_a = 2'd2; u_d = 8'h3C;
        c_pend = 1'b1; c_a = 2'd1;
        do_reset();
        repeat (8) tick(1'b0);

        // Both requesters valid for four consecutive cycles.
        for (int i = 0; i < 4; i++) begin
            if (!u_pend) new_upd();
            if (!c_pend) new_clr();
            tick(1'b0);
        end
        repeat (3) tick(1'b0);

        // Reinit in the same cycle as an update request.
        new_upd();
        tick(1'b1);
        repeat (8) tick(1'b0);

        // Back-to-back update stream.
        for (int a = 0; a < N; a++) begin
            u_pend = 1'b1;
            u_a = AW'(a);
            u_d = W'($urandom);
            tick(1'b0);
        end
        repeat (2) tick(1'b0);

        // Reset while the sweep is presenting address 2.
        do_reset();
        repeat (3) tick(1'b0);
        chk("pre_rst_addr", o_waddr_r, 2);
        do_reset();
        repeat (8) tick(1'b0);

        // Random traffic with occasional reinit.
        for (int i = 0; i < 400; i++) begin
            if (!u_pend && ($urandom_range(0, 2) != 0)) new_upd();
            if (!c_pend && ($urandom_range(0, 2) != 0)) new_clr();
            tick($urandom_range(0, 39) == 0);
        end
        repeat (10) tick(1'b0);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
